// File: rtl/ram3_dual_port.sv
// True dual-port character RAM for the 70x30 text screen.
// Port A feeds the VGA glyph pipeline, port B takes game-logic writes; both registered, 1-cycle read.
module ram3_dual_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_a,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic in_range_a, in_range_b;
    logic we_a, we_b;

    assign in_range_a = {1'b0, address_a} < DEPTH_L;
    assign in_range_b = {1'b0, address_b} < DEPTH_L;
    assign we_a       = wren_a && in_range_a && !reset;
    assign we_b       = wren_b && in_range_b && !reset;

    // Port B write is scheduled last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we_a) mem[address_a] <= data_a;
        if (we_b) mem[address_b] <= data_b;
    end

    // Reads sample mem before this edge's writes land: the other port sees old data,
    // while a port's own write is forwarded straight to its output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_a <= '0;
            q_b <= '0;
        end else begin
            if (!in_range_a)  q_a <= '0;
            else if (wren_a)  q_a <= data_a;
            else              q_a <= mem[address_a];

            if (!in_range_b)  q_b <= '0;
            else if (wren_b)  q_b <= data_b;
            else              q_b <= mem[address_b];
        end
    end

endmodule

// File: tb/tb_ram3_dual_port.sv
// Directed self-checking bench for ram3_dual_port with the screen-sized DEPTH of 2100.
module tb_ram3_dual_port;
    localparam int DW = 8;
    localparam int AW = 12;
    localparam int DEPTH = 2100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] address_a = '0, address_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          wren_a = 1'b0, wren_b = 1'b0;
    logic [DW-1:0] q_a, q_b;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [DEPTH];

    ram3_dual_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .address_a(address_a), .address_b(address_b),
        .data_a(data_a), .data_b(data_b),
        .wren_a(wren_a), .wren_b(wren_b),
        .q_a(q_a), .q_b(q_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset clears outputs asynchronously
        #1 reset = 1'b1;
        #1;
        chk("rst_qa", q_a, 8'h00);
        chk("rst_qb", q_b, 8'h00);
        cyc();
        reset = 1'b0;

        // Load 'A' so the async reset has something to clear
        address_b = 12'd10; data_b = 8'h41; wren_b = 1'b1;
        cyc();
        model[10] = 8'h41;
        wren_b = 1'b0;
        address_a = 12'd10;
        cyc();
        chk("pre_rst_qa", q_a, 8'h41);

        // Mid-cycle reset, then a write attempt while held in reset
        #2 reset = 1'b1;
        #1;
        chk("async_rst_qa", q_a, 8'h00);
        chk("async_rst_qb", q_b, 8'h00);
        address_b = 12'd5; data_b = 8'h55; wren_b = 1'b1;
        cyc();
        chk("rst_hold_qb", q_b, 8'h00);
        wren_b = 1'b0;
        reset = 1'b0;
        address_a = 12'd5;
        cyc();
        chk("rst_wr_blocked", q_a, 8'h00);
        address_a = 12'd10;
        cyc();
        chk("rst_keeps_mem", q_a, 8'h41);

        // Fill the screen through port B
        for (int a = 0; a < DEPTH; a++) begin
            address_b = AW'(a);
            data_b = 8'h61 + DW'(a % 26);
            wren_b = 1'b1;
            cyc();
            model[a] = 8'h61 + DW'(a % 26);
            if (a == 0 || a == DEPTH - 1) chk("fill_wt_qb", q_b, model[a]);
        end
        wren_b = 1'b0;
        address_a = 12'd70;
        cyc();
        chk("rd70", q_a, 8'h73);
        address_a = 12'd2099;
        cyc();
        chk("rd2099", q_a, 8'h74);

        // Mixed-port collision returns old data on A
        address_a = 12'd100; address_b = 12'd100; data_b = 8'h7A; wren_b = 1'b1;
        cyc();
        chk("mixed_old", q_a, 8'h77);
        model[100] = 8'h7A;
        wren_b = 1'b0;
        cyc();
        chk("mixed_new", q_a, 8'h7A);

        // Same-port write-through
        address_b = 12'd61; data_b = 8'h30; wren_b = 1'b1;
        cyc();
        chk("wt_qb", q_b, 8'h30);
        model[61] = 8'h30;
        wren_b = 1'b0;

        // Dual write to the same address: B wins the array
        address_a = 12'd300; data_a = 8'h11; wren_a = 1'b1;
        address_b = 12'd300; data_b = 8'h22; wren_b = 1'b1;
        cyc();
        chk("dual_qa", q_a, 8'h11);
        chk("dual_qb", q_b, 8'h22);
        model[300] = 8'h22;
        wren_a = 1'b0; wren_b = 1'b0;
        cyc();
        chk("dual_stored", q_a, 8'h22);

        // Dual write to different addresses
        address_a = 12'd400; data_a = 8'h44; wren_a = 1'b1;
        address_b = 12'd401; data_b = 8'h45; wren_b = 1'b1;
        cyc();
        model[400] = 8'h44; model[401] = 8'h45;
        wren_a = 1'b0; wren_b = 1'b0;
        cyc();
        chk("diff_a", q_a, 8'h44);
        chk("diff_b", q_b, 8'h45);

        // Out of range writes and reads
        address_b = 12'd2100; data_b = 8'hFF; wren_b = 1'b1;
        address_a = 12'd4000; data_a = 8'hEE; wren_a = 1'b1;
        cyc();
        chk("oor_wr_qb", q_b, 8'h00);
        chk("oor_wr_qa", q_a, 8'h00);
        wren_a = 1'b0; wren_b = 1'b0;
        address_a = 12'd4095; address_b = 12'd2100;
        cyc();
        chk("oor_rd_qa", q_a, 8'h00);
        chk("oor_rd_qb", q_b, 8'h00);
        address_a = 12'd2099;
        cyc();
        chk("oor_2099", q_a, 8'h74);

        // Sweep: no word disturbed by any of the above
        for (int a = 0; a < DEPTH; a++) begin
            address_a = AW'(a);
            address_b = AW'(DEPTH - 1 - a);
            cyc();
            chk("sweep_a", q_a, model[a]);
            chk("sweep_b", q_b, model[DEPTH - 1 - a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
